// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C master byte engine.
// FSM state encoding, bit-phase numbering and I2C direction/address constants.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    FETCH,
    FETCH_WAIT,
    DATA,
    DATA_ACK,
    STOP
  } state_e;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  localparam int I2C_ADDR_W = 7;

  // SCL is pulled low during the first half of every bit.
  function automatic logic scl_low(input logic [1:0] phase);
    return (phase == P0) || (phase == P1);
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-SCL-period divider: phase advances every clk_div cycles, phase_last_o marks each phase's final cycle.
// Synchronous hold_i parks it at P0/count 0 so the next bit starts with a full first phase.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int unsigned clk_div = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold_i,
  output logic [1:0] phase_o,
  output logic       phase_last_o
);

  localparam int unsigned CW = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(clk_div - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (hold_i) begin
      cnt_d   = '0;
      phase_d = P0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= P0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o      = phase_q;
  assign phase_last_o = !hold_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, address+W, byte_count FIFO bytes with ACK checks, STOP; busy from the cycle after accept.
// One FIFO pop per byte (data registered one cycle later); NACK or an empty FIFO aborts straight to STOP.
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int unsigned clk_div = 250
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_req,
  input  logic [I2C_ADDR_W-1:0] slave_addr,
  input  logic [7:0]            byte_count,
  output logic                  fifo_rd_req,
  input  logic [7:0]            fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  sda_in,
  output logic                  scl_oe,
  output logic                  sda_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  nack,
  output logic                  underflow
);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic       ack_q, ack_d;
  logic       nack_q, nack_d;
  logic       uf_q, uf_d;
  logic       done_q, done_d;

  logic [1:0] phase;
  logic       phase_last;
  logic       timer_hold;
  logic       bit_end;
  logic       last_byte;

  assign timer_hold = (state_q == IDLE) || (state_q == FETCH) || (state_q == FETCH_WAIT);
  assign bit_end    = phase_last && (phase == P3);
  // The address ACK precedes any data byte; a data ACK closes the last one when one byte remains.
  assign last_byte  = (state_q == ADDR_ACK) ? (cnt_q == 8'd0) : (cnt_q == 8'd1);

  i2c_bit_timer #(
    .clk_div(clk_div)
  ) u_bit_timer (
    .clock       (clock),
    .reset       (reset),
    .hold_i      (timer_hold),
    .phase_o     (phase),
    .phase_last_o(phase_last)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    ack_d       = ack_q;
    nack_d      = nack_q;
    uf_d        = uf_q;
    done_d      = 1'b0;
    fifo_rd_req = 1'b0;
    scl_oe      = 1'b0;
    sda_oe      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = START;
          shift_d = {slave_addr, I2C_WRITE};
          cnt_d   = byte_count;
          bit_d   = 3'd0;
          nack_d  = 1'b0;
          uf_d    = 1'b0;
        end
      end

      START: begin
        sda_oe = (phase != P0);
        scl_oe = (phase == P3);
        if (bit_end) begin
          state_d = ADDR;
        end
      end

      ADDR, DATA: begin
        scl_oe = scl_low(phase);
        sda_oe = ~shift_q[7];
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
          end
        end
      end

      ADDR_ACK, DATA_ACK: begin
        scl_oe = scl_low(phase);
        if (phase_last && (phase == P2)) begin
          ack_d = sda_in;
        end
        if (bit_end) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else if (last_byte) begin
            state_d = STOP;
          end else begin
            if (state_q == DATA_ACK) begin
              cnt_d = cnt_q - 8'd1;
            end
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
        if (fifo_empty) begin
          uf_d    = 1'b1;
          state_d = STOP;
        end else begin
          fifo_rd_req = 1'b1;
          state_d     = FETCH_WAIT;
        end
      end

      FETCH_WAIT: begin
        scl_oe  = 1'b1;
        sda_oe  = 1'b1;
        shift_d = fifo_rd_data;
        bit_d   = 3'd0;
        state_d = DATA;
      end

      STOP: begin
        scl_oe = (phase == P0);
        sda_oe = (phase != P3);
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= 8'd0;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      uf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      uf_q    <= uf_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign nack      = nack_q;
  assign underflow = uf_q;

endmodule
